// File: rtl/p2s_pkg.sv
// Shared definitions for the serialiser blocks: FSM state encoding and a
// constant-evaluable ceil(log2) helper used for derived counter widths.
package p2s_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } p2s_state_e;

   function automatic int unsigned p2s_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/p2s_holdreg.sv
// Single-entry valid/ready holding register; pop frees the entry so the
// next word is accepted on the following edge.
module p2s_holdreg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         pop,
   output logic [W-1:0] data_out,
   output logic         full
);

   assign din_ready = !full;

   // Accept requires !full and pop requires full, so the two never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 1'b0;
         data_out <= '0;
      end else if (din_valid && !full) begin
         full     <= 1'b1;
         data_out <= din;
      end else if (pop) begin
         full     <= 1'b0;
      end
   end

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter: one-word holding buffer feeding a shifter
// that streams words back-to-back with frame sync on each first bit.
module p2s_stream
   import p2s_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter bit LSB_FIRST = 1'b0,
   parameter int CNT_W     = p2s_clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              dout,
   output logic              dout_valid,
   output logic              fs,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              busy,
   output logic              underrun
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   p2s_state_e        state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [DATA_W-1:0] buf_data;
   logic              buf_full;
   logic              word_end;
   logic              pop;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return LSB_FIRST ? w[0] : w[DATA_W-1];
   endfunction

   assign word_end = (state == ST_SHIFT) && (bit_cnt == LAST);
   assign pop      = buf_full && ((state == ST_IDLE) || word_end);

   always_comb begin
      shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
   end

   p2s_holdreg #(.W(DATA_W)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .pop       (pop),
      .data_out  (buf_data),
      .full      (buf_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         fs         <= 1'b0;
         bit_cnt    <= '0;
         busy       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (pop) begin
            // Load from the buffer: covers both IDLE start and seamless word chaining.
            state      <= ST_SHIFT;
            shreg      <= buf_data;
            dout       <= first_bit(buf_data);
            dout_valid <= 1'b1;
            fs         <= 1'b1;
            bit_cnt    <= '0;
            busy       <= 1'b1;
         end else begin
            case (state)
               ST_SHIFT: begin
                  if (word_end) begin
                     state      <= ST_IDLE;
                     shreg      <= '0;
                     dout       <= 1'b0;
                     dout_valid <= 1'b0;
                     fs         <= 1'b0;
                     bit_cnt    <= '0;
                     busy       <= 1'b0;
                     underrun   <= 1'b1;
                  end else begin
                     shreg   <= shreg_nxt;
                     dout    <= first_bit(shreg_nxt);
                     fs      <= 1'b0;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
                  fs         <= 1'b0;
                  bit_cnt    <= '0;
                  busy       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_p2s_stream.sv
// Directed bench for p2s_stream: MSB/LSB-first 16-bit and 8-bit instances.
module tb_p2s_stream;

   logic clk = 1'b0;
   logic rst;

   logic [15:0] din0, din1;
   logic [7:0]  din2;
   logic        vld0, vld1, vld2;
   logic        rdy0, rdy1, rdy2;
   logic        dout0, dout1, dout2;
   logic        dv0, dv1, dv2;
   logic        fs0, fs1, fs2;
   logic [3:0]  bc0, bc1;
   logic [2:0]  bc2;
   logic        busy0, busy1, busy2;
   logic        ur0, ur1, ur2;

   int vecs = 0;
   int miss = 0;

   always #5 clk = ~clk;

   p2s_stream #(.DATA_W(16), .LSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .din(din0), .din_valid(vld0), .din_ready(rdy0),
      .dout(dout0), .dout_valid(dv0), .fs(fs0), .bit_cnt(bc0), .busy(busy0), .underrun(ur0));

   p2s_stream #(.DATA_W(16), .LSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(vld1), .din_ready(rdy1),
      .dout(dout1), .dout_valid(dv1), .fs(fs1), .bit_cnt(bc1), .busy(busy1), .underrun(ur1));

   p2s_stream #(.DATA_W(8), .LSB_FIRST(1'b0)) dut2 (
      .clk(clk), .rst(rst), .din(din2), .din_valid(vld2), .din_ready(rdy2),
      .dout(dout2), .dout_valid(dv2), .fs(fs2), .bit_cnt(bc2), .busy(busy2), .underrun(ur2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] w;
      logic [15:0] words [3];
      logic [7:0]  b8;
      logic [47:0] stream;
      int          acc [3];
      int          idx, stalls, nbits, nfs, dvseen;
      bit          take;

      rst = 1'b1;
      din0 = '0; din1 = '0; din2 = '0;
      vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
      tick();
      tick();
      chk("rst_dout", dout0, 0);
      chk("rst_dv", dv0, 0);
      chk("rst_fs", fs0, 0);
      chk("rst_bitcnt", bc0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_underrun", ur0, 0);
      rst = 1'b0;
      tick();
      chk("rst_ready", rdy0, 1);

      // Single word 0x1111, MSB first
      w = 16'h1111;
      din0 = w; vld0 = 1'b1;
      tick();
      vld0 = 1'b0;
      chk("t1_ready_full", rdy0, 0);
      chk("t1_latency_dv", dv0, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t1_dout%0d", i), dout0, ((i % 4) == 3) ? 1 : 0);
         chk($sformatf("t1_fs%0d", i), fs0, (i == 0) ? 1 : 0);
         chk($sformatf("t1_dv%0d", i), dv0, 1);
         chk($sformatf("t1_bc%0d", i), bc0, i);
         chk($sformatf("t1_ur%0d", i), ur0, 0);
         tick();
      end
      chk("t1_underrun", ur0, 1);
      chk("t1_idle_dv", dv0, 0);
      chk("t1_idle_busy", busy0, 0);
      tick();
      chk("t1_underrun_off", ur0, 0);
      chk("t1_idle_bc", bc0, 0);

      // Back-to-back A5A5 then 0F0F
      din0 = 16'hA5A5; vld0 = 1'b1;
      tick();
      chk("t2_ready_full", rdy0, 0);
      din0 = 16'h0F0F;
      tick();
      for (int i = 0; i < 32; i++) begin
         w = (i < 16) ? 16'hA5A5 : 16'h0F0F;
         if (i == 0) chk("t2_ready_drained", rdy0, 1);
         if (i == 1) begin
            chk("t2_ready_second", rdy0, 0);
            vld0 = 1'b0;
         end
         chk($sformatf("t2_dout%0d", i), dout0, w[15 - (i % 16)]);
         chk($sformatf("t2_fs%0d", i), fs0, ((i % 16) == 0) ? 1 : 0);
         chk($sformatf("t2_dv%0d", i), dv0, 1);
         chk($sformatf("t2_bc%0d", i), bc0, i % 16);
         chk($sformatf("t2_ur%0d", i), ur0, 0);
         tick();
      end
      chk("t2_underrun", ur0, 1);
      chk("t2_idle_dv", dv0, 0);
      tick();

      // Backpressure: three words with din_valid held
      words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'h8001;
      idx = 0; stalls = 0; nbits = 0; nfs = 0; stream = '0;
      acc[0] = -1; acc[1] = -1; acc[2] = -1;
      din0 = words[0]; vld0 = 1'b1;
      for (int c = 0; c < 80; c++) begin
         take = vld0 && rdy0;
         if (vld0 && !rdy0) stalls++;
         if (take) acc[idx] = c;
         tick();
         if (take) begin
            idx++;
            if (idx == 3) vld0 = 1'b0;
            else din0 = words[idx];
         end
         if (dv0) begin
            stream = {stream[46:0], dout0};
            nbits++;
            if (fs0) nfs++;
         end
      end
      chk("t3_acc0", acc[0], 0);
      chk("t3_acc1", acc[1], 2);
      chk("t3_acc2", acc[2], 18);
      chk("t3_stalls", stalls, 16);
      chk("t3_nbits", nbits, 48);
      chk("t3_nfs", nfs, 3);
      chk("t3_stream", stream, 48'h1234_BEEF_8001);

      // Reset mid-word with buffer full
      din0 = 16'hCAFE; vld0 = 1'b1;
      tick();
      din0 = 16'h1357;
      tick();
      tick();
      vld0 = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("t4_bc7", bc0, 7);
      chk("t4_full", rdy0, 0);
      rst = 1'b1;
      tick();
      chk("t4_dout", dout0, 0);
      chk("t4_dv", dv0, 0);
      chk("t4_fs", fs0, 0);
      chk("t4_bc", bc0, 0);
      chk("t4_busy", busy0, 0);
      chk("t4_ur", ur0, 0);
      chk("t4_ready", rdy0, 1);
      rst = 1'b0;
      dvseen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dv0 || busy0 || ur0) dvseen++;
      end
      chk("t4_silent", dvseen, 0);

      // LSB first, word 0x0001
      din1 = 16'h0001; vld1 = 1'b1;
      tick();
      vld1 = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t5_dout%0d", i), dout1, (i == 0) ? 1 : 0);
         chk($sformatf("t5_fs%0d", i), fs1, (i == 0) ? 1 : 0);
         chk($sformatf("t5_bc%0d", i), bc1, i);
         tick();
      end
      chk("t5_underrun", ur1, 1);

      // 8-bit instance, word 0xC3
      b8 = 8'hC3;
      din2 = b8; vld2 = 1'b1;
      tick();
      vld2 = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t6_dout%0d", i), dout2, b8[7 - i]);
         chk($sformatf("t6_fs%0d", i), fs2, (i == 0) ? 1 : 0);
         chk($sformatf("t6_dv%0d", i), dv2, 1);
         chk($sformatf("t6_bc%0d", i), bc2, i);
         tick();
      end
      chk("t6_underrun", ur2, 1);
      chk("t6_idle_dv", dv2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
